// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and index helpers for the register-file write-back arbiter.
`ifndef REGFILE_WB_ARBITER_PKG_SV
`define REGFILE_WB_ARBITER_PKG_SV
package regfile_wb_arbiter_pkg;

   localparam int unsigned DEF_NUM_REQ = 2;
   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_ADDR_W  = 5;
   localparam int unsigned REG_ZERO    = 0;

   // (a + b) mod n for operands already below n
   function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                            input int unsigned n);
      int unsigned s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

endpackage
`endif

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus (sources -> arbiter) and register-file write port (arbiter -> file).
interface regfile_wb_arbiter_if
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W
) ();
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      rf_write_en;
   logic [ADDR_W-1:0]         rf_write_addr;
   logic [DATA_W-1:0]         rf_write_data;

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, rf_write_en, rf_write_addr, rf_write_data
   );

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, rf_write_en, rf_write_addr, rf_write_data
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr (wrapping) wins.
module rr_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid
);
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'(wrap_add(32'(ptr), k, NUM_REQ));
         if (!gnt_valid && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            gnt_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NUM_REQ buffered write-back sources,
// round-robin, dropping r0 writes and exporting a pending-write mask for hazard stalls.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ),
   parameter int unsigned NREG    = 1 << ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_wb_arbiter_if.slave   bus,
   input  logic                  freeze,
   output logic [NREG-1:0]       pending_mask,
   output logic                  wr_conflict
);
   logic [NUM_REQ-1:0] held, is_r0, cand, gnt, retire, accept;
   logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
   logic [DATA_W-1:0]  slot_data [NUM_REQ];
   logic [IDX_W-1:0]   rr_ptr, gnt_idx;
   logic               gnt_valid;

   always_comb begin
      is_r0 = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         is_r0[i] = held[i] && (slot_addr[i] == ADDR_W'(REG_ZERO));
         cand[i]  = held[i] && !is_r0[i] && !freeze;
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
      .req       (cand),
      .ptr       (rr_ptr),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Outputs are forced to their idle values while rst is low so no stale write escapes.
   always_comb begin
      retire            = is_r0 | gnt;
      bus.req_ready     = rst ? (~held | retire) : '1;
      accept            = bus.req_valid & bus.req_ready;
      bus.rf_write_en   = rst & gnt_valid;
      bus.rf_write_addr = bus.rf_write_en ? slot_addr[gnt_idx] : '0;
      bus.rf_write_data = bus.rf_write_en ? slot_data[gnt_idx] : '0;
   end

   always_comb begin
      pending_mask = '0;
      wr_conflict  = 1'b0;
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (held[i] && !is_r0[i]) pending_mask[slot_addr[i]] = 1'b1;
            for (int unsigned j = i + 1; j < NUM_REQ; j++) begin
               if (held[i] && held[j] && !is_r0[i] && slot_addr[i] == slot_addr[j])
                  wr_conflict = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         held   <= '0;
         rr_ptr <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept[i])      held[i] <= 1'b1;
            else if (retire[i]) held[i] <= 1'b0;
         end
         if (gnt_valid) rr_ptr <= IDX_W'(wrap_add(32'(gnt_idx), 1, NUM_REQ));
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rst && accept[i]) begin
            slot_addr[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
            slot_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural register file on the write port.
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic [31:0] pending_mask;
   logic        wr_conflict;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] rf_model [32] = '{default: '0};

   regfile_wb_arbiter_if #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) bus ();

   regfile_wb_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .freeze       (freeze),
      .pending_mask (pending_mask),
      .wr_conflict  (wr_conflict)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.rf_write_en) rf_model[bus.rf_write_addr] <= bus.rf_write_data;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; freeze = 1'b0; bus.req_valid = 2'b00;
      cyc(); cyc();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; freeze = 1'b0;
      bus.req_valid = 2'b11; bus.req_addr = {5'd4, 5'd3}; bus.req_data = {32'h1111_1111, 32'h2222_2222};
      for (int c = 0; c < 2; c++) begin
         #2;
         checks++; if (bus.rf_write_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.rf_write_en); end
         checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", bus.req_ready); end
         checks++; if (pending_mask !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", pending_mask); end
         cyc();
      end
      rst = 1'b1; bus.req_valid = 2'b00;
      #2;
      checks++; if (pending_mask !== 32'h0) begin failures++; $display("FAIL reset_nocapture_mask got=%h exp=0", pending_mask); end
      checks++; if (bus.rf_write_en !== 1'b0) begin failures++; $display("FAIL reset_after_en got=%b exp=0", bus.rf_write_en); end
      checks++; if (bus.rf_write_addr !== 5'd0 || bus.rf_write_data !== 32'h0) begin failures++; $display("FAIL reset_after_bus got=%h/%h exp=0/0", bus.rf_write_addr, bus.rf_write_data); end
      cyc();
   endtask

   task automatic test_single();
      do_reset();
      bus.req_valid = 2'b01; bus.req_addr = {5'd0, 5'd5}; bus.req_data = {32'h0, 32'hDEAD_BEEF};
      #2;
      checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL single_ready0 got=%b exp=11", bus.req_ready); end
      cyc();
      bus.req_valid = 2'b00;
      #2;
      checks++; if (bus.rf_write_en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", bus.rf_write_en); end
      checks++; if (bus.rf_write_addr !== 5'd5) begin failures++; $display("FAIL single_addr got=%0d exp=5", bus.rf_write_addr); end
      checks++; if (bus.rf_write_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", bus.rf_write_data); end
      checks++; if (pending_mask !== 32'h0000_0020) begin failures++; $display("FAIL single_mask got=%h exp=00000020", pending_mask); end
      checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL single_ready1 got=%b exp=11", bus.req_ready); end
      cyc();
      #2;
      checks++; if (bus.rf_write_en !== 1'b0) begin failures++; $display("FAIL single_idle_en got=%b exp=0", bus.rf_write_en); end
      checks++; if (pending_mask !== 32'h0) begin failures++; $display("FAIL single_idle_mask got=%h exp=0", pending_mask); end
      checks++; if (rf_model[5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_file got=%h exp=deadbeef", rf_model[5]); end
      cyc();
   endtask

   task automatic test_contention();
      int          c0 = 0;
      int          c1 = 0;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic [1:0]  er;
      do_reset();
      bus.req_valid = 2'b11; bus.req_addr = {5'd4, 5'd3};
      bus.req_data = {32'hB000_0000, 32'hA000_0000};
      #2;
      checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL cont_ready0 got=%b exp=11", bus.req_ready); end
      c0 += int'(bus.req_ready[0]); c1 += int'(bus.req_ready[1]);
      cyc();
      for (int k = 0; k < 6; k++) begin
         bus.req_data = {32'hB000_0000 + 32'(c1), 32'hA000_0000 + 32'(c0)};
         ea = (k % 2 == 0) ? 5'd3 : 5'd4;
         ed = ((k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(k / 2);
         er = (k % 2 == 0) ? 2'b01 : 2'b10;
         #2;
         checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== ea) begin failures++; $display("FAIL cont_grant k=%0d got=%b/%0d exp=1/%0d", k, bus.rf_write_en, bus.rf_write_addr, ea); end
         checks++; if (bus.rf_write_data !== ed) begin failures++; $display("FAIL cont_data k=%0d got=%h exp=%h", k, bus.rf_write_data, ed); end
         checks++; if (bus.req_ready !== er) begin failures++; $display("FAIL cont_ready k=%0d got=%b exp=%b", k, bus.req_ready, er); end
         c0 += int'(bus.req_ready[0]); c1 += int'(bus.req_ready[1]);
         cyc();
      end
      bus.req_valid = 2'b00;
      cyc(); cyc();
      #2;
      checks++; if (bus.rf_write_en !== 1'b0) begin failures++; $display("FAIL cont_drain_en got=%b exp=0", bus.rf_write_en); end
      checks++; if (rf_model[3] !== 32'hA000_0003) begin failures++; $display("FAIL cont_file3 got=%h exp=a0000003", rf_model[3]); end
      checks++; if (rf_model[4] !== 32'hB000_0003) begin failures++; $display("FAIL cont_file4 got=%h exp=b0000003", rf_model[4]); end
      cyc();
   endtask

   task automatic test_r0_drop();
      do_reset();
      bus.req_valid = 2'b11; bus.req_addr = {5'd0, 5'd9}; bus.req_data = {32'h0000_1234, 32'h0000_0055};
      #2;
      checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL r0_ready0 got=%b exp=11", bus.req_ready); end
      cyc();
      bus.req_valid = 2'b10; bus.req_addr = {5'd6, 5'd9}; bus.req_data = {32'h0000_0066, 32'h0000_0055};
      #2;
      checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== 5'd9 || bus.rf_write_data !== 32'h55) begin failures++; $display("FAIL r0_src0 got=%b/%0d/%h exp=1/9/00000055", bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data); end
      checks++; if (pending_mask !== 32'h0000_0200) begin failures++; $display("FAIL r0_mask got=%h exp=00000200", pending_mask); end
      checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL r0_ready1 got=%b exp=11", bus.req_ready); end
      cyc();
      bus.req_valid = 2'b00;
      #2;
      checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== 5'd6 || bus.rf_write_data !== 32'h66) begin failures++; $display("FAIL r0_refill got=%b/%0d/%h exp=1/6/00000066", bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data); end
      checks++; if (pending_mask !== 32'h0000_0040) begin failures++; $display("FAIL r0_refill_mask got=%h exp=00000040", pending_mask); end
      cyc();
      #2;
      checks++; if (bus.rf_write_en !== 1'b0 || pending_mask !== 32'h0) begin failures++; $display("FAIL r0_idle got=%b/%h exp=0/0", bus.rf_write_en, pending_mask); end
      checks++; if (rf_model[0] !== 32'h0) begin failures++; $display("FAIL r0_file got=%h exp=0", rf_model[0]); end
      cyc();
   endtask

   task automatic test_freeze();
      do_reset();
      freeze = 1'b1;
      bus.req_valid = 2'b11; bus.req_addr = {5'd11, 5'd10}; bus.req_data = {32'hC000_0001, 32'hC000_0000};
      #2;
      checks++; if (bus.req_ready !== 2'b11) begin failures++; $display("FAIL frz_ready0 got=%b exp=11", bus.req_ready); end
      cyc();
      bus.req_valid = 2'b00;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++; if (bus.rf_write_en !== 1'b0) begin failures++; $display("FAIL frz_en c=%0d got=%b exp=0", c, bus.rf_write_en); end
         checks++; if (pending_mask !== 32'h0000_0C00) begin failures++; $display("FAIL frz_mask c=%0d got=%h exp=00000c00", c, pending_mask); end
         checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL frz_ready c=%0d got=%b exp=00", c, bus.req_ready); end
         cyc();
      end
      freeze = 1'b0;
      #2;
      checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== 5'd10 || bus.rf_write_data !== 32'hC000_0000) begin failures++; $display("FAIL frz_rel0 got=%b/%0d/%h exp=1/10/c0000000", bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data); end
      checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL frz_rel0_ready got=%b exp=01", bus.req_ready); end
      cyc();
      #2;
      checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== 5'd11 || bus.rf_write_data !== 32'hC000_0001) begin failures++; $display("FAIL frz_rel1 got=%b/%0d/%h exp=1/11/c0000001", bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data); end
      cyc();
      #2;
      checks++; if (bus.rf_write_en !== 1'b0 || pending_mask !== 32'h0) begin failures++; $display("FAIL frz_idle got=%b/%h exp=0/0", bus.rf_write_en, pending_mask); end
      cyc();
   endtask

   task automatic test_conflict_reset();
      do_reset();
      freeze = 1'b1;
      bus.req_valid = 2'b11; bus.req_addr = {5'd7, 5'd7}; bus.req_data = {32'hE000_0001, 32'hE000_0000};
      #2;
      checks++; if (wr_conflict !== 1'b0) begin failures++; $display("FAIL conf_empty got=%b exp=0", wr_conflict); end
      cyc();
      bus.req_valid = 2'b00;
      #2;
      checks++; if (wr_conflict !== 1'b1) begin failures++; $display("FAIL conf_pulse got=%b exp=1", wr_conflict); end
      checks++; if (pending_mask !== 32'h0000_0080) begin failures++; $display("FAIL conf_mask got=%h exp=00000080", pending_mask); end
      cyc();
      freeze = 1'b0; rst = 1'b0;
      #2;
      checks++; if (bus.rf_write_en !== 1'b0) begin failures++; $display("FAIL conf_rst_en got=%b exp=0", bus.rf_write_en); end
      cyc();
      rst = 1'b1;
      #2;
      checks++; if (pending_mask !== 32'h0 || wr_conflict !== 1'b0) begin failures++; $display("FAIL conf_after_rst got=%h/%b exp=0/0", pending_mask, wr_conflict); end
      checks++; if (bus.rf_write_en !== 1'b0 || bus.req_ready !== 2'b11) begin failures++; $display("FAIL conf_after_rst_port got=%b/%b exp=0/11", bus.rf_write_en, bus.req_ready); end
      cyc();
      #2;
      checks++; if (rf_model[7] !== 32'h0) begin failures++; $display("FAIL conf_file7 got=%h exp=0", rf_model[7]); end
      cyc();
   endtask

   initial begin
      bus.req_valid = 2'b00;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      test_reset();
      test_single();
      test_contention();
      test_r0_drop();
      test_freeze();
      test_conflict_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
